// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and sizing helpers for the fifo reader
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;

  // Counter width able to hold 0..n inclusive
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// rtl/fifo_reader_skid.sv - circular skid buffer holding captured FIFO words
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          push_data,
  input  logic                           pop,
  output logic [cnt_width(DEPTH)-1:0]    occupancy,
  output logic [DATA_WIDTH-1:0]          head_data,
  output logic                           not_empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= (tail == LAST) ? '0 : tail + 1'b1;
      end
      if (pop) head <= (head == LAST) ? '0 : head + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign head_data = mem[head];
  assign not_empty = (occupancy != '0);

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - credit-based FIFO consumer feeding a valid/ready stream
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SKID_DEPTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  Read_enable,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [31:0]           rd_count
);

  localparam int CW = cnt_width(SKID_DEPTH);

  rd_state_t             state;
  logic [CW-1:0]         occupancy;
  logic [CW-1:0]         inflight;
  logic [RD_LATENCY-1:0] lat_sr;
  logic [31:0]           rd_count_q;
  logic                  credit_ok;
  logic                  push;
  logic                  pop;
  logic                  not_empty;
  logic [DATA_WIDTH-1:0] head_data;

  // Reads already issued reserve a slot, so the buffer can never overflow
  assign credit_ok   = ({1'b0, occupancy} + {1'b0, inflight}) < (CW + 1)'(SKID_DEPTH);
  assign Read_enable = enable && !empty && credit_ok && !reset;
  assign push        = lat_sr[RD_LATENCY-1];
  assign pop         = m_valid && m_ready;
  assign m_valid     = not_empty;
  assign m_data      = head_data;
  assign busy        = (state != IDLE);
  assign rd_count    = rd_count_q;

  fifo_reader_skid #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (SKID_DEPTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(data_out),
    .pop      (pop),
    .occupancy(occupancy),
    .head_data(head_data),
    .not_empty(not_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      inflight   <= '0;
      lat_sr     <= '0;
      rd_count_q <= '0;
    end else begin
      lat_sr <= (lat_sr << 1) | RD_LATENCY'(Read_enable);
      case ({Read_enable, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (pop) rd_count_q <= rd_count_q + 32'd1;
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= (inflight != '0 || occupancy != '0) ? DRAIN : IDLE;
        DRAIN: begin
          if (enable)                                   state <= RUN;
          else if (inflight == '0 && occupancy == '0)   state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
